// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: hands a single-port byte memory between a CPU and an external loader/monitor,
// halting the CPU before a grant and restarting it at a selectable address on release.
module cpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_raddr,
  input  logic [ADDR_WIDTH-1:0] cpu_waddr,
  input  logic                  cpu_write,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] cpu_start,
  input  logic                  ext_req,
  output logic                  ext_grant,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic                  ext_write,
  input  logic [7:0]            ext_wdata,
  output logic [7:0]            ext_rdata,
  input  logic                  ext_run,
  input  logic [ADDR_WIDTH-1:0] ext_start,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);
  typedef enum logic [2:0] {BOOT, RUN, DRAIN, GRANTED, RESTART} state_t;
  state_t state, nxt;
  logic granted;
  always_comb begin
    nxt = (state == BOOT || state == RESTART) ? RUN :
          (state == RUN)     ? (ext_req ? DRAIN : RUN) :
          (state == DRAIN)   ? (cpu_halted ? GRANTED : DRAIN) :
          (state == GRANTED) ? (ext_req ? GRANTED : RESTART) : BOOT;
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      cpu_start <= RESET_VECTOR;
      cpu_reset <= 1'b1;
      cpu_halt  <= 1'b0;
      ext_grant <= 1'b0;
    end else begin
      state     <= nxt;
      cpu_reset <= nxt == BOOT || nxt == RESTART;
      cpu_halt  <= nxt == DRAIN || nxt == GRANTED;
      ext_grant <= nxt == GRANTED;
      if (state == GRANTED && ext_run) cpu_start <= ext_start;
    end
  end
  assign granted   = state == GRANTED;
  assign mem_raddr = granted ? ext_addr : cpu_raddr;
  assign mem_waddr = granted ? ext_addr : cpu_waddr;
  assign mem_wdata = granted ? ext_wdata : cpu_wdata;
  assign mem_write = granted ? ext_write : (state != BOOT && state != RESTART) && cpu_write;
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed vectors against cpu_mem_arbiter with a 2-cycle-latency memory model.
module tb_cpu_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [8:0] cpu_raddr = '0, cpu_waddr = '0, cpu_start, ext_addr = '0, ext_start = '0;
  logic [8:0] mem_raddr, mem_waddr;
  logic cpu_write = 1'b0, cpu_halted = 1'b0, ext_req = 1'b0, ext_write = 1'b0, ext_run = 1'b0;
  logic cpu_halt, cpu_reset, ext_grant, mem_write;
  logic [7:0] cpu_wdata = '0, ext_wdata = '0, cpu_rdata, ext_rdata, mem_wdata, mem_rdata, rd1;
  logic [7:0] mem [0:511];
  int n_vec = 0, n_bad = 0;
  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted), .cpu_reset(cpu_reset),
    .cpu_start(cpu_start), .ext_req(ext_req), .ext_grant(ext_grant), .ext_addr(ext_addr),
    .ext_write(ext_write), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_run(ext_run),
    .ext_start(ext_start), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_write) mem[mem_waddr] <= mem_wdata;
    rd1       <= mem[mem_raddr];
    mem_rdata <= rd1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    tick();
    tick();
    cpu_write = 1'b1;
    #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_grant", ext_grant, 0);
    chk("rst_start", cpu_start, 0);
    chk("boot_wr_forced0", mem_write, 0);
    reset = 1'b0;
    cpu_write = 1'b0;
    #1;
    chk("boot_cpu_reset", cpu_reset, 1);
    tick();
    chk("run_cpu_reset", cpu_reset, 0);
    cpu_waddr = 9'd5; cpu_wdata = 8'h33; cpu_write = 1'b1; cpu_raddr = 9'd7;
    #1;
    chk("run_wr", mem_write, 1);
    chk("run_waddr", mem_waddr, 5);
    chk("run_wdata", mem_wdata, 8'h33);
    chk("run_raddr", mem_raddr, 7);
    tick();
    cpu_write = 1'b0; cpu_halted = 1'b1;
    tick();
    tick();
    chk("halt_instr_no_halt", cpu_halt, 0);
    chk("halt_instr_no_reset", cpu_reset, 0);
    cpu_halted = 1'b0; ext_req = 1'b1; ext_addr = 9'h10;
    tick();
    chk("drain_halt", cpu_halt, 1);
    chk("drain_grant", ext_grant, 0);
    chk("drain_cpu_port", mem_raddr, 7);
    tick();
    tick();
    cpu_halted = 1'b1;
    #1;
    chk("drain_wait_grant", ext_grant, 0);
    tick();
    chk("granted_grant", ext_grant, 1);
    chk("granted_halt", cpu_halt, 1);
    ext_wdata = 8'hA5; ext_write = 1'b1;
    #1;
    chk("ext_wr", mem_write, 1);
    chk("ext_waddr", mem_waddr, 9'h10);
    chk("ext_wdata", mem_wdata, 8'hA5);
    tick();
    ext_write = 1'b0;
    tick();
    chk("ext_rd_lat1", ext_rdata, 0);
    tick();
    chk("ext_rd_lat2", ext_rdata, 8'hA5);
    chk("cpu_rdata_mirror", cpu_rdata, 8'hA5);
    ext_addr = 9'd5;
    tick();
    tick();
    chk("ext_rd_cpu_data", ext_rdata, 8'h33);
    ext_run = 1'b1; ext_start = 9'h41;
    tick();
    chk("run_latch_1", cpu_start, 9'h41);
    ext_start = 9'h40;
    tick();
    ext_run = 1'b0;
    chk("run_latch_last", cpu_start, 9'h40);
    chk("still_granted", ext_grant, 1);
    ext_req = 1'b0;
    tick();
    cpu_write = 1'b1; ext_write = 1'b1;
    #1;
    chk("restart_reset", cpu_reset, 1);
    chk("restart_start", cpu_start, 9'h40);
    chk("restart_halt", cpu_halt, 0);
    chk("restart_grant", ext_grant, 0);
    chk("restart_wr_forced0", mem_write, 0);
    cpu_halted = 1'b0; ext_write = 1'b0;
    tick();
    chk("rerun_reset", cpu_reset, 0);
    chk("rerun_cpu_wr", mem_write, 1);
    cpu_write = 1'b0; ext_run = 1'b1; ext_start = 9'h1FF;
    tick();
    ext_run = 1'b0;
    chk("run_ignored_in_run", cpu_start, 9'h40);
    ext_req = 1'b1; cpu_halted = 1'b1;
    tick();
    ext_req = 1'b0;
    chk("pulse_drain_halt", cpu_halt, 1);
    chk("pulse_drain_grant", ext_grant, 0);
    tick();
    chk("pulse_granted", ext_grant, 1);
    tick();
    chk("pulse_restart_grant", ext_grant, 0);
    chk("pulse_restart_reset", cpu_reset, 1);
    chk("pulse_restart_start", cpu_start, 9'h40);
    tick();
    chk("pulse_run", cpu_reset, 0);
    ext_req = 1'b1;
    tick();
    tick();
    chk("regrant", ext_grant, 1);
    ext_write = 1'b1; cpu_write = 1'b0; reset = 1'b1;
    tick();
    chk("midgrant_rst_grant", ext_grant, 0);
    chk("midgrant_rst_wr", mem_write, 0);
    chk("midgrant_rst_start", cpu_start, 0);
    chk("midgrant_rst_reset", cpu_reset, 1);
    chk("midgrant_rst_halt", cpu_halt, 0);
    reset = 1'b0; ext_write = 1'b0;
    tick();
    chk("boot_req_run", cpu_halt, 0);
    chk("boot_req_run_reset", cpu_reset, 0);
    tick();
    chk("boot_req_drain", cpu_halt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, memory address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, CPU start address after block reset.
REQ-003 SHALL have the following ports (name direction width meaning); clock and reset are clk and reset, reset synchronous, active-high:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_raddr / cpu_waddr  in  ADDR_WIDTH  CPU read/write address
- cpu_write  in  1  CPU byte write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data to CPU
- cpu_halt  out  1  halt request to CPU
- cpu_halted  in  1  CPU halted status
- cpu_reset  out  1  reset to CPU
- cpu_start  out  ADDR_WIDTH  CPU start address
- ext_req  in  1  external master (loader/monitor) requests memory
- ext_grant  out  1  external master owns memory
- ext_addr  in  ADDR_WIDTH  external read/write address
- ext_write  in  1  external byte write strobe
- ext_wdata  in  8  external write data
- ext_rdata  out  8  read data to external master
- ext_run  in  1  one-cycle pulse: restart CPU at ext_start on release
- ext_start  in  ADDR_WIDTH  restart address, sampled with ext_run
- mem_raddr / mem_waddr  out  ADDR_WIDTH  memory read/write address
- mem_write  out  1  memory write strobe
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data (2-cycle read latency)

Function
REQ-004 SHALL implement a registered FSM with states BOOT, RUN, DRAIN, GRANTED, RESTART.
REQ-005 BOOT: cpu_reset=1, cpu_halt=0, cpu_start=latched start; next state RUN.
REQ-006 RUN: cpu_reset=0, cpu_halt=0, ext_grant=0; on ext_req=1 go to DRAIN.
REQ-007 RUN with cpu_halted=1 and ext_req=0 (halt instruction) SHALL stay in RUN; no automatic restart.
REQ-008 DRAIN: cpu_halt=1; CPU keeps the memory port; when cpu_halted=1, go to GRANTED next cycle. When ext_req and cpu_halted are both 1 in RUN, the block SHALL still pass through one DRAIN cycle.
REQ-009 GRANTED: cpu_halt=1, ext_grant=1; mem_raddr=mem_waddr=ext_addr, mem_write=ext_write, mem_wdata=ext_wdata.
REQ-010 In all states other than GRANTED, the memory port SHALL be driven from the cpu_* signals. In BOOT and RESTART, mem_write SHALL be forced 0.
REQ-011 The memory mux SHALL be combinational from the registered state; no added address or data latency. External reads therefore see mem_rdata 2 cycles after ext_addr is applied.
REQ-012 cpu_rdata and ext_rdata SHALL both equal mem_rdata at all times.
REQ-013 ext_run=1 in GRANTED SHALL latch ext_start as the restart address. In other states ext_run SHALL be ignored. The last pulse before release wins.
REQ-014 GRANTED with ext_req=0: go to RESTART; ext_grant SHALL drop in the same cycle the state leaves GRANTED.
REQ-015 RESTART: cpu_reset=1 for exactly one cycle, cpu_halt=0, cpu_start=latched restart address (unchanged if no ext_run was seen); next state RUN.
REQ-016 ext_req falling in DRAIN SHALL NOT abort the sequence: on cpu_halted=1, go to GRANTED, then immediately to RESTART when ext_req is still 0.
REQ-017 ext_req rising in RESTART or BOOT SHALL be serviced from RUN, via DRAIN, on the following cycles.
REQ-018 cpu_start SHALL be a register, stable outside the cycle where ext_run is latched.

Reset
REQ-019 reset=1 SHALL force state BOOT, latched start=RESET_VECTOR, ext_grant=0, cpu_halt=0, cpu_reset=1.
REQ-020 reset asserted in any state, including mid-grant, SHALL revoke the grant the next cycle and produce a CPU reset to RESET_VECTOR.

Verification
REQ-021 Reset released -> cpu_reset=1 for one cycle with cpu_start=0, then RUN; cpu_* writes appear on mem_*.
REQ-022 RUN, ext_req=1, cpu_halted rises 3 cycles later -> cpu_halt=1 from next cycle; ext_grant=1 one cycle after cpu_halted.
REQ-023 GRANTED, ext write 0xA5 to 0x10, then read 0x10 -> mem_write=1 with addr 0x10; ext_rdata=0xA5 2 cycles after read address.
REQ-024 GRANTED, ext_run with ext_start=0x40, then ext_req=0 -> one-cycle cpu_reset with cpu_start=0x40, cpu_halt=0, grant removed.
REQ-025 ext_req pulsed for 1 cycle in RUN -> DRAIN, GRANTED for one cycle, then RESTART with previous start address; no ext write occurs.
REQ-026 reset asserted while in GRANTED with ext_write=1 -> mem_write driven from cpu_write (forced 0 in BOOT), ext_grant=0, cpu_start=RESET_VECTOR.
